// File: rtl/command_frame_parser_pkg.sv
// Shared types and constants for the command frame parser slice.
package cmd_pkg;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_EMIT = 3'd4
  } cmd_parse_state_t;

  localparam int CMD_ADDR_WIDTH = 16;
  localparam int CMD_DATA_WIDTH = 32;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/command_frame_parser_if.sv
// Host byte stream in, register-write strobe out.
// Byte handshake: a byte transfers on a rising edge where byte_valid_i && byte_ready_o;
// the source holds data stable while valid is high and not yet accepted.
interface command_frame_parser_if;
  import cmd_pkg::*;

  logic [7:0]                byte_data_i;
  logic                      byte_valid_i;
  logic                      byte_ready_o;
  logic [CMD_ADDR_WIDTH-1:0] cmd_addr_o;
  logic [CMD_DATA_WIDTH-1:0] cmd_data_o;
  logic                      cmd_valid_o;

  modport master (
    output byte_data_i, byte_valid_i,
    input  byte_ready_o, cmd_addr_o, cmd_data_o, cmd_valid_o
  );

  modport slave (
    input  byte_data_i, byte_valid_i,
    output byte_ready_o, cmd_addr_o, cmd_data_o, cmd_valid_o
  );

endinterface

// File: rtl/command_frame_parser_sat_counter8.sv
// 8-bit counter that sticks at 8'hFF; asynchronous clear.
module sat_counter8 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/command_frame_parser.sv
// Parses SYNC/ADDR[2]/DATA[4]/CSUM frames into one-cycle register writes,
// with an inter-byte timeout and saturating error counters.
module command_frame_parser
  import cmd_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  command_frame_parser_if.slave bus,
  output logic [7:0]            csum_err_count_o,
  output logic [7:0]            timeout_err_count_o,
  output cmd_parse_state_t      state_o
);

  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

  cmd_parse_state_t          state, state_next;
  logic [2:0]                sub_cnt;
  logic [GW-1:0]             gap_cnt;
  logic [7:0]                xor_acc;
  logic [CMD_ADDR_WIDTH-1:0] addr_sr;
  logic [CMD_DATA_WIDTH-1:0] data_sr;
  logic [CMD_ADDR_WIDTH-1:0] cmd_addr_q;
  logic [CMD_DATA_WIDTH-1:0] cmd_data_q;

  logic accept;
  logic in_frame;
  logic timeout_hit;
  logic csum_ok;
  logic csum_fail;

  assign accept   = bus.byte_valid_i && (state != ST_EMIT);
  assign in_frame = (state == ST_ADDR) || (state == ST_DATA) || (state == ST_CSUM);
  // Fires on the edge that would make the gap counter reach the limit; an accepted byte wins.
  assign timeout_hit = in_frame && !accept && (gap_cnt == GW'(TIMEOUT_CYCLES - 1));
  assign csum_ok     = (state == ST_CSUM) && accept && (bus.byte_data_i == xor_acc);
  assign csum_fail   = (state == ST_CSUM) && accept && (bus.byte_data_i != xor_acc);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      ST_HUNT: if (accept && (bus.byte_data_i == SYNC_BYTE)) state_next = ST_ADDR;
      ST_ADDR: begin
        if (timeout_hit)                    state_next = ST_HUNT;
        else if (accept && sub_cnt == 3'd1) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (timeout_hit)                    state_next = ST_HUNT;
        else if (accept && sub_cnt == 3'd3) state_next = ST_CSUM;
      end
      ST_CSUM: begin
        if (timeout_hit)    state_next = ST_HUNT;
        else if (csum_ok)   state_next = ST_EMIT;
        else if (csum_fail) state_next = ST_HUNT;
      end
      ST_EMIT: state_next = ST_HUNT;
      default: state_next = ST_HUNT;
    endcase
  end

  // Output logic
  always_comb begin
    bus.byte_ready_o = 1'b1;
    bus.cmd_valid_o  = 1'b0;
    if (state == ST_EMIT) begin
      bus.byte_ready_o = 1'b0;
      bus.cmd_valid_o  = 1'b1;
    end
  end

  assign bus.cmd_addr_o = cmd_addr_q;
  assign bus.cmd_data_o = cmd_data_q;
  assign state_o        = state;

  // Datapath: byte position, gap timer, running XOR, shift registers, write registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sub_cnt    <= 3'd0;
      gap_cnt    <= '0;
      xor_acc    <= 8'd0;
      addr_sr    <= '0;
      data_sr    <= '0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
    end else begin
      if (state_next != state) sub_cnt <= 3'd0;
      else if (accept)         sub_cnt <= sub_cnt + 3'd1;

      if (!in_frame || accept || timeout_hit) gap_cnt <= '0;
      else                                    gap_cnt <= gap_cnt + GW'(1);

      if (state == ST_HUNT && accept && bus.byte_data_i == SYNC_BYTE) begin
        xor_acc <= 8'd0;
      end else if ((state == ST_ADDR || state == ST_DATA) && accept) begin
        xor_acc <= xor_acc ^ bus.byte_data_i;
      end

      if (state == ST_ADDR && accept) addr_sr <= {addr_sr[7:0], bus.byte_data_i};
      if (state == ST_DATA && accept) data_sr <= {data_sr[23:0], bus.byte_data_i};

      if (csum_ok) begin
        cmd_addr_q <= addr_sr;
        cmd_data_q <= data_sr;
      end
    end
  end

  sat_counter8 u_csum_err (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (csum_fail),
    .count (csum_err_count_o)
  );

  sat_counter8 u_timeout_err (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (timeout_hit),
    .count (timeout_err_count_o)
  );

endmodule

// File: tb/tb_command_frame_parser.sv
// Directed bench for command_frame_parser: framing, checksum, timeout, saturation, reset.
module tb_command_frame_parser;
  import cmd_pkg::*;

  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       csum_err;
  logic [7:0]       to_err;
  cmd_parse_state_t dut_state;

  int total = 0;
  int bad   = 0;
  int writes_seen = 0;
  logic [47:0] exp_q[$];

  command_frame_parser_if bus();

  command_frame_parser #(.TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .bus                 (bus),
    .csum_err_count_o    (csum_err),
    .timeout_err_count_o (to_err),
    .state_o             (dut_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic send_byte(input logic [7:0] b);
    int budget = 100;
    @(negedge clk);
    while (!bus.byte_ready_o && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("ready_wait_timeout", {63'd0, bus.byte_ready_o}, 64'd1);
    bus.byte_data_i  = b;
    bus.byte_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] f, input bit expect_write);
    if (expect_write) exp_q.push_back({f[55:40], f[39:8]});
    for (int i = 0; i < 8; i++) send_byte(f[63-8*i -: 8]);
    chk("strobe_after_csum", {63'd0, bus.cmd_valid_o}, {63'd0, expect_write});
    @(posedge clk);
    #1;
    chk("strobe_single_cycle", {63'd0, bus.cmd_valid_o}, 64'd0);
  endtask

  // Scoreboard: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && bus.cmd_valid_o) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        chk("spurious_write", {63'd0, bus.cmd_valid_o}, 64'd0);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        chk("write_addr", {48'd0, bus.cmd_addr_o}, {48'd0, e[47:32]});
        chk("write_data", {32'd0, bus.cmd_data_o}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"},   64'(dut_state), 64'(ST_HUNT));
    chk({tag, "_ready"},   {63'd0, bus.byte_ready_o}, 64'd1);
    chk({tag, "_valid"},   {63'd0, bus.cmd_valid_o}, 64'd0);
    chk({tag, "_addr"},    {48'd0, bus.cmd_addr_o}, 64'd0);
    chk({tag, "_data"},    {32'd0, bus.cmd_data_o}, 64'd0);
    chk({tag, "_csum_err"}, {56'd0, csum_err}, 64'd0);
    chk({tag, "_to_err"},   {56'd0, to_err}, 64'd0);
  endtask

  localparam logic [63:0] FR_K1   = 64'hA5_0000_00002000_20;
  localparam logic [63:0] FR_G2   = 64'hA5_0050_0000007F_2F;
  localparam logic [63:0] FR_BAD  = 64'hA5_0010_00000100_00;
  localparam logic [63:0] FR_GOOD = 64'hA5_1234_DEADBEEF_04;
  localparam logic [63:0] FR_BADS = 64'hA5_0001_00000000_A5;

  initial begin
    bus.byte_data_i  = 8'h00;
    bus.byte_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // Good frame, k1 = 0x2000
    send_frame(FR_K1, 1'b1);
    chk("k1_addr_hold", {48'd0, bus.cmd_addr_o}, 64'h0000);
    chk("k1_data_hold", {32'd0, bus.cmd_data_o}, 64'h00002000);

    // Leading garbage, then a good frame
    send_byte(8'h12);
    send_byte(8'h34);
    chk("garbage_stays_hunt", 64'(dut_state), 64'(ST_HUNT));
    send_frame(FR_G2, 1'b1);
    chk("garbage_csum_err", {56'd0, csum_err}, 64'd0);
    chk("garbage_to_err", {56'd0, to_err}, 64'd0);

    // Bad checksum, then an immediate good frame
    send_frame(FR_BAD, 1'b0);
    chk("bad_csum_count", {56'd0, csum_err}, 64'd1);
    chk("bad_csum_hold_addr", {48'd0, bus.cmd_addr_o}, 64'h0050);
    send_frame(FR_GOOD, 1'b1);

    // Mismatching checksum equal to SYNC must not start a new frame
    for (int i = 0; i < 8; i++) send_byte(FR_BADS[63-8*i -: 8]);
    chk("bad_sync_csum_hunt", 64'(dut_state), 64'(ST_HUNT));
    chk("bad_sync_csum_count", {56'd0, csum_err}, 64'd2);

    // Stall after 3 bytes for the full timeout
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h11);
    repeat (TO - 1) @(posedge clk);
    #1;
    chk("stall_before_limit_state", 64'(dut_state), 64'(ST_DATA));
    chk("stall_before_limit_to", {56'd0, to_err}, 64'd0);
    @(posedge clk);
    #1;
    chk("timeout_count", {56'd0, to_err}, 64'd1);
    chk("timeout_state", 64'(dut_state), 64'(ST_HUNT));

    // Same stall, but a byte arrives on the last allowed cycle
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h11);
    repeat (TO - 1) @(posedge clk);
    send_byte(8'h22);
    chk("late_byte_no_timeout", {56'd0, to_err}, 64'd1);
    chk("late_byte_state", 64'(dut_state), 64'(ST_DATA));
    exp_q.push_back({16'h0011, 32'h22334455});
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h11);
    chk("late_frame_strobe", {63'd0, bus.cmd_valid_o}, 64'd1);
    @(posedge clk);
    #1;

    // Saturate the checksum error counter
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 8; i++) send_byte(FR_BAD[63-8*i -: 8]);
    end
    chk("csum_saturate", {56'd0, csum_err}, 64'hFF);
    chk("to_unchanged", {56'd0, to_err}, 64'd1);

    // Reset mid-DATA, asserted between clock edges
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h22);
    send_byte(8'h33);
    chk("pre_reset_state", 64'(dut_state), 64'(ST_DATA));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_frame(FR_GOOD, 1'b1);
    chk("post_reset_csum_err", {56'd0, csum_err}, 64'd0);
    chk("post_reset_to_err", {56'd0, to_err}, 64'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("pending_writes", 64'(exp_q.size()), 64'd0);
    chk("write_total", 64'(writes_seen), 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/command_frame_parser.md
# command_frame_parser

- Converts the host byte stream (UART/FIFO side) into single-cycle register writes (16-bit address, 32-bit data) for the parameter controller.
- Validates each framed command with a checksum.
- Recovers from stalls with an inter-byte timeout.
- Keeps saturating error counters for bring-up debug.
- Sits directly upstream of the controller and drives its write port.

## Interface

Parameters:
- TIMEOUT_CYCLES, 100000: max idle cycles between bytes inside a frame before the frame is abandoned.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk_i  input  1  single clock.
- rst_i  input  1  reset, asynchronous and active-high.
- byte_data_i  input  8  incoming byte.
- byte_valid_i  input  1  byte present.
- byte_ready_o  output  1  parser accepts byte; transfer when valid && ready.
- cmd_addr_o  output  16  write address.
- cmd_data_o  output  32  write data.
- cmd_valid_o  output  1  one-cycle write strobe.
- csum_err_count_o  output  8  saturating count of checksum failures.
- timeout_err_count_o  output  8  saturating count of timed-out frames.

## Operation

- Frame: SYNC, ADDR[15:8], ADDR[7:0], DATA[31:24], DATA[23:16], DATA[15:8], DATA[7:0], CSUM. Eight bytes total.
- CSUM is the XOR of the 6 address/data bytes. SYNC is excluded.
- States: HUNT, ADDR, DATA, CSUM, EMIT. Substep counter is 3 bits.
- HUNT:
  - Bytes other than SYNC_BYTE are discarded silently.
  - SYNC_BYTE moves to ADDR and clears the running XOR.
- ADDR: 2 bytes, MSB first, shifted into an address shift register. Then DATA.
- DATA: 4 bytes, MSB first. Then CSUM.
- Running XOR accumulates every ADDR/DATA byte.
- CSUM:
  - Byte equals running XOR: move to EMIT.
  - Otherwise: increment csum_err_count_o (saturating at 8'hFF) and return to HUNT.
  - A mismatching byte is not re-examined as SYNC.
- EMIT:
  - Lasts exactly one cycle.
  - cmd_valid_o=1 with the assembled addr/data; byte_ready_o=0.
  - Returns to HUNT.
- byte_ready_o=1 in every state except EMIT.
- Timeout:
  - Gap counter resets on each accepted byte and while in HUNT.
  - In ADDR/DATA/CSUM, if the counter reaches TIMEOUT_CYCLES with no accepted byte: increment timeout_err_count_o (saturating) and go to HUNT.
  - If a byte is accepted on the same cycle the limit is reached, the byte wins and no timeout is counted.
- SYNC_BYTE inside the payload is ordinary data. There is no escaping and no resync mid-frame.
- Address is not range-checked. The downstream controller ignores unmapped addresses.

## Timing

- Reset (async assert, synchronous release), all outputs and state:
  - State = HUNT.
  - cmd_valid_o=0, cmd_addr_o=0, cmd_data_o=0.
  - Both error counters = 0, byte_ready_o=1.
  - Gap counter and XOR = 0.
- Latency: CSUM byte accepted at edge N; cmd_valid_o is high for cycle N→N+1 only.
- cmd_addr_o/cmd_data_o are registered and hold the last emitted value until the next EMIT.
- Throughput: at most one byte per cycle. One frame per 9 cycles minimum (8 bytes + EMIT).
- Reset asserted mid-frame drops the partial frame with no write and no error count.
- No write-side backpressure. The downstream stage accepts every strobe.

## Structure

- Shared package cmd_pkg holds:
  - state enum cmd_parse_state_t.
  - CMD_ADDR_WIDTH=16, CMD_DATA_WIDTH=32.
  - DEFAULT_SYNC_BYTE.
- One natural sub-module, sat_counter8: 8-bit saturating counter with inc and async clear. Instantiated twice.
- The gap counter is sized $clog2(TIMEOUT_CYCLES+1).

## Test plan

- Good frame A5 00 00 00 00 20 00 20 (k1 = 0x2000):
  - cmd_valid_o pulses exactly once, 1 cycle after the last byte.
  - addr=0x0000, data=0x00002000.
- Leading garbage 12 34 followed by a good frame A5 00 50 00 00 00 7F 2F:
  - Exactly one write, addr=0x0050, data=0x0000007F.
  - Error counters stay at 0.
- Frame with bad CSUM A5 00 10 00 00 01 00 00:
  - No write; csum_err_count_o=1.
  - A good frame sent immediately after is written.
- Stall after 3 bytes for TIMEOUT_CYCLES cycles (TIMEOUT_CYCLES=16 in bench):
  - timeout_err_count_o=1, state returns to HUNT, no write.
  - A byte arriving on exactly cycle 16 instead continues the frame.
- 300 bad-checksum frames: csum_err_count_o saturates at 0xFF.
- Assert rst_i mid-DATA:
  - All outputs take reset values asynchronously.
  - The next full frame is written normally.
